alien_wave_ctrl: RTL and testbench
==================================

Name: alien_wave_ctrl

Overview:
Game-level sequencer for the alien formation. Owns the wave/lives state machine and drives the alien group's reset, freeze (fsync gating), movement speed and alien-bullet fire requests. Consumes the group's status (aliens_remaining, alien_reached_paddle) and the player-hit event. Sits between the top level and alien_group; all decisions are taken on frame boundaries (fsync).

Parameters:
TOTAL_ALIENS, 40, formation size; must equal NUM_ROWS*NUM_COLS
START_LIVES, 3, lives loaded at game start
BASE_SPEED, 1, wave-0 speed (px/frame)
WAVE_STEP, 1, speed added per wave
RAMP_SHIFT, 3, +1 speed per 2^RAMP_SHIFT aliens killed
MAX_SPEED, 8, speed saturation
FIRE_BASE, 60, wave-0 frames between fire requests
FIRE_STEP, 6, period reduction per wave
FIRE_MIN, 12, period floor
SPAWN_FRAMES, 60; CLEAR_FRAMES, 90; RESPAWN_FRAMES, 120: state dwell times in frames

Ports:
pixel_clk  in  1  pixel clock, single clock domain
rst_n  in  1  asynchronous active-low reset
fsync  in  1  one-cycle frame strobe
start_btn  in  1  synchronous level; rising edge detected internally
aliens_remaining  in  $clog2(TOTAL_ALIENS+1)  live alien count
alien_reached_paddle  in  1  level from alien group
player_hit  in  1  pulse, any cycle
speed  out  8  formation speed
group_rst  out  1  active-high reset to alien group
freeze  out  1  top gates alien-group fsync with ~freeze
fire_req  out  1  one-cycle alien-bullet fire request
wave_num  out  4  current wave, saturates at 15
lives  out  2  remaining lives
game_over  out  1  high in GAME_OVER
state  out  3  wave_state_t, debug

Behaviour:
- Reset (async, rst_n=0): state=IDLE, speed=0, group_rst=1, freeze=1, fire_req=0, wave_num=0, lives=START_LIVES, game_over=0, timers/flags cleared. Reset mid-frame takes effect immediately; release synchronous to pixel_clk.
- Event capture: player_hit and alien_reached_paddle set sticky flags on any cycle; flags consumed and cleared on the fsync cycle (a hit coinciding with fsync counts in that frame). start_btn rising edge likewise sticky until consumed.
- All state/timer/speed/fire updates occur only on the fsync edge; outputs change the cycle after fsync is sampled (1-cycle latency).
- States:
  IDLE: group_rst=1, freeze=1. start edge -> SPAWN, wave_num=0, lives=START_LIVES.
  SPAWN: group_rst=1, freeze=1, timer=SPAWN_FRAMES. Timer 0 -> PLAY.
  PLAY: group_rst=0, freeze=0. Per-fsync priority: reached_paddle -> GAME_OVER (lives=0); else player_hit -> lives==1 ? GAME_OVER (lives=0) : LIFE_LOST (lives-1); else aliens_remaining==0 -> CLEARED.
  LIFE_LOST: freeze=1, group_rst=0 (formation preserved), RESPAWN_FRAMES -> PLAY. Hits ignored/cleared.
  CLEARED: freeze=1, CLEAR_FRAMES -> SPAWN, wave_num+1 saturating at 15.
  GAME_OVER: game_over=1, freeze=1, group_rst=0 (formation stays visible). start edge -> SPAWN with wave_num=0, lives=START_LIVES.
- Timers: loaded on state entry with N; decrement per fsync; exit on fsync when timer==1 (state lasts exactly N frames).
- Speed (PLAY only, else held): speed = min(MAX_SPEED, BASE_SPEED + wave_num*WAVE_STEP + ((TOTAL_ALIENS-aliens_remaining)>>RAMP_SHIFT)); computed at ≥10 bits, saturated to 8. aliens_remaining>TOTAL_ALIENS treated as TOTAL_ALIENS. Set to 0 in IDLE.
- Fire: period = max(FIRE_MIN, FIRE_BASE - wave_num*FIRE_STEP), signed-safe. Frame counter runs only in PLAY; fire_req pulses one cycle after the fsync on which counter reaches period, counter restarts at 0. Counter cleared on PLAY entry. Never asserted outside PLAY or when aliens_remaining==0.

Decomposition:
- Package params: typedef enum logic[2:0] wave_state_t {IDLE, SPAWN, PLAY, LIFE_LOST, CLEARED, GAME_OVER}; default constants (START_LIVES, dwell frames, speed/fire constants).
- Sub-module frame_timer: loadable down-counter ticking on fsync, outputs done; instantiated for dwell timer (fire counter inline).

Test Plan:
- Reset then start_btn edge, SPAWN_FRAMES=60 -> group_rst high for exactly 60 fsyncs, PLAY entered one cycle after 60th fsync, speed=1.
- PLAY wave 0, remaining drops 40->24 -> speed=1+0+2=3; wave 15 -> speed saturates at 8.
- PLAY wave 0 -> fire_req every 60 frames, single-cycle; wave 9 -> period 12 (floor), not 6.
- player_hit pulse mid-frame with lives=3 -> LIFE_LOST on next fsync, lives=2, freeze=1 for 120 frames, group_rst stays 0; with lives=1 -> GAME_OVER, lives=0.
- Same frame: reached_paddle, player_hit, remaining=0 -> GAME_OVER; only player_hit + remaining=0 -> LIFE_LOST.
- rst_n asserted in PLAY mid-frame -> outputs at reset values same cycle, no fire_req; remaining=0 in PLAY -> CLEARED, 90 frames, SPAWN, wave_num=1.

Source files
------------

// File: rtl/alien_wave_ctrl_pkg.sv
// rtl/alien_wave_ctrl_pkg.sv - shared state type and default constants for the wave sequencer
package alien_wave_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SPAWN     = 3'd1,
    PLAY      = 3'd2,
    LIFE_LOST = 3'd3,
    CLEARED   = 3'd4,
    GAME_OVER = 3'd5
  } wave_state_t;

  localparam int DEF_TOTAL_ALIENS   = 40;
  localparam int DEF_START_LIVES    = 3;
  localparam int DEF_BASE_SPEED     = 1;
  localparam int DEF_WAVE_STEP      = 1;
  localparam int DEF_RAMP_SHIFT     = 3;
  localparam int DEF_MAX_SPEED      = 8;
  localparam int DEF_FIRE_BASE      = 60;
  localparam int DEF_FIRE_STEP      = 6;
  localparam int DEF_FIRE_MIN       = 12;
  localparam int DEF_SPAWN_FRAMES   = 60;
  localparam int DEF_CLEAR_FRAMES   = 90;
  localparam int DEF_RESPAWN_FRAMES = 120;

  // Dwell timer width; must hold the longest dwell in frames.
  localparam int TIMER_W = 8;

endpackage

// File: rtl/alien_wave_ctrl_if.sv
// rtl/alien_wave_ctrl_if.sv - status inputs and control outputs between sequencer and game top
interface alien_wave_ctrl_if #(
  parameter int TOTAL_ALIENS = 40
) ();
  localparam int AW = $clog2(TOTAL_ALIENS + 1);

  logic          fsync;
  logic          start_btn;
  logic [AW-1:0] aliens_remaining;
  logic          alien_reached_paddle;
  logic          player_hit;
  logic [7:0]    speed;
  logic          group_rst;
  logic          freeze;
  logic          fire_req;
  logic [3:0]    wave_num;
  logic [1:0]    lives;
  logic          game_over;
  logic [2:0]    state;

  // Sequencer side.
  modport master (
    input  fsync, start_btn, aliens_remaining, alien_reached_paddle, player_hit,
    output speed, group_rst, freeze, fire_req, wave_num, lives, game_over, state
  );

  // Game-top / alien-group side.
  modport slave (
    output fsync, start_btn, aliens_remaining, alien_reached_paddle, player_hit,
    input  speed, group_rst, freeze, fire_req, wave_num, lives, game_over, state
  );
endinterface

// File: rtl/alien_wave_ctrl_frame_timer.sv
// rtl/alien_wave_ctrl_frame_timer.sv - loadable frame down-counter, done while count is 1
module alien_wave_ctrl_frame_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  output logic         done
);
  logic [W-1:0] count_q, count_d;

  // Load wins over tick so a state entry on an fsync starts the full dwell.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (tick && count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  // Exit is taken on the fsync that sees 1, so a load of N lasts N frames.
  assign done = (count_q == W'(1));
endmodule

// File: rtl/alien_wave_ctrl.sv
// rtl/alien_wave_ctrl.sv - wave/lives sequencer driving alien group reset, freeze, speed and fire
module alien_wave_ctrl
  import alien_wave_ctrl_pkg::*;
#(
  parameter int TOTAL_ALIENS   = DEF_TOTAL_ALIENS,
  parameter int START_LIVES    = DEF_START_LIVES,
  parameter int BASE_SPEED     = DEF_BASE_SPEED,
  parameter int WAVE_STEP      = DEF_WAVE_STEP,
  parameter int RAMP_SHIFT     = DEF_RAMP_SHIFT,
  parameter int MAX_SPEED      = DEF_MAX_SPEED,
  parameter int FIRE_BASE      = DEF_FIRE_BASE,
  parameter int FIRE_STEP      = DEF_FIRE_STEP,
  parameter int FIRE_MIN       = DEF_FIRE_MIN,
  parameter int SPAWN_FRAMES   = DEF_SPAWN_FRAMES,
  parameter int CLEAR_FRAMES   = DEF_CLEAR_FRAMES,
  parameter int RESPAWN_FRAMES = DEF_RESPAWN_FRAMES
) (
  input  logic              pixel_clk,
  input  logic              rst_n,
  alien_wave_ctrl_if.master bus
);
  localparam int AW = $clog2(TOTAL_ALIENS + 1);

  wave_state_t  state_q, state_d;
  logic [7:0]   speed_q, speed_d;
  logic [3:0]   wave_q, wave_d;
  logic [1:0]   lives_q, lives_d;
  logic         group_rst_q, group_rst_d;
  logic         freeze_q, freeze_d;
  logic         fire_q, fire_d;
  logic         game_over_q, game_over_d;
  logic [7:0]   fire_cnt_q, fire_cnt_d;
  logic         hit_q, hit_d, paddle_q, paddle_d, start_q, start_d;
  logic         start_prev_q, start_prev_d;

  logic               hit_now, paddle_now, start_now;
  logic [AW-1:0]      remaining_c;
  logic [9:0]         kill_c, speed_raw;
  logic [7:0]         speed_sat, fire_period;
  int                 fire_raw;
  logic               timer_load, timer_done;
  logic [TIMER_W-1:0] timer_val;

  // Events seen this frame, including ones arriving on the fsync cycle itself.
  assign hit_now    = hit_q | bus.player_hit;
  assign paddle_now = paddle_q | bus.alien_reached_paddle;
  assign start_now  = start_q | (bus.start_btn & ~start_prev_q);

  assign remaining_c = (bus.aliens_remaining > AW'(TOTAL_ALIENS)) ? AW'(TOTAL_ALIENS)
                                                                  : bus.aliens_remaining;
  assign kill_c      = 10'(TOTAL_ALIENS) - 10'(remaining_c);
  assign speed_raw   = 10'(BASE_SPEED) + 10'(wave_q) * 10'(WAVE_STEP) + (kill_c >> RAMP_SHIFT);
  assign speed_sat   = (speed_raw > 10'(MAX_SPEED)) ? 8'(MAX_SPEED) : speed_raw[7:0];

  // Signed so late waves floor at FIRE_MIN instead of wrapping.
  assign fire_raw    = FIRE_BASE - int'(wave_q) * FIRE_STEP;
  assign fire_period = (fire_raw < FIRE_MIN) ? 8'(FIRE_MIN) : 8'(fire_raw);

  // Dwell timer reloads on every state change; non-dwell states load 0 and ignore it.
  assign timer_load = bus.fsync && (state_d != state_q);
  always_comb begin
    case (state_d)
      SPAWN:     timer_val = TIMER_W'(SPAWN_FRAMES);
      LIFE_LOST: timer_val = TIMER_W'(RESPAWN_FRAMES);
      CLEARED:   timer_val = TIMER_W'(CLEAR_FRAMES);
      default:   timer_val = '0;
    endcase
  end

  alien_wave_ctrl_frame_timer #(.W(TIMER_W)) u_dwell (
    .clk      (pixel_clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (timer_val),
    .tick     (bus.fsync),
    .done     (timer_done)
  );

  // Next-state, lives/wave/speed/fire decisions; everything advances only on fsync.
  always_comb begin
    state_d      = state_q;
    wave_d       = wave_q;
    lives_d      = lives_q;
    speed_d      = speed_q;
    fire_cnt_d   = fire_cnt_q;
    fire_d       = 1'b0;
    hit_d        = hit_now;
    paddle_d     = paddle_now;
    start_d      = start_now;
    start_prev_d = bus.start_btn;
    if (bus.fsync) begin
      hit_d    = 1'b0;
      paddle_d = 1'b0;
      start_d  = 1'b0;
      case (state_q)
        IDLE, GAME_OVER: begin
          if (start_now) begin
            state_d = SPAWN;
            wave_d  = 4'd0;
            lives_d = 2'(START_LIVES);
          end
        end
        SPAWN:     if (timer_done) state_d = PLAY;
        PLAY: begin
          if (paddle_now) begin
            state_d = GAME_OVER;
            lives_d = 2'd0;
          end else if (hit_now) begin
            if (lives_q == 2'd1) begin
              state_d = GAME_OVER;
              lives_d = 2'd0;
            end else begin
              state_d = LIFE_LOST;
              lives_d = lives_q - 2'd1;
            end
          end else if (remaining_c == '0) begin
            state_d = CLEARED;
          end
        end
        LIFE_LOST: if (timer_done) state_d = PLAY;
        CLEARED: begin
          if (timer_done) begin
            state_d = SPAWN;
            if (wave_q != 4'hF) wave_d = wave_q + 4'd1;
          end
        end
        default:   state_d = IDLE;
      endcase
      if (state_d == PLAY) begin
        speed_d = speed_sat;
        if (state_q != PLAY) begin
          fire_cnt_d = 8'd0;
        end else if (fire_cnt_q + 8'd1 >= fire_period) begin
          fire_cnt_d = 8'd0;
          fire_d     = (remaining_c != '0);
        end else begin
          fire_cnt_d = fire_cnt_q + 8'd1;
        end
      end
      if (state_d == IDLE) speed_d = 8'd0;
    end
    group_rst_d = (state_d == IDLE) || (state_d == SPAWN);
    freeze_d    = (state_d != PLAY);
    game_over_d = (state_d == GAME_OVER);
  end

  // Single register stage for state, sticky flags and all outputs.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      speed_q      <= 8'd0;
      wave_q       <= 4'd0;
      lives_q      <= 2'(START_LIVES);
      group_rst_q  <= 1'b1;
      freeze_q     <= 1'b1;
      fire_q       <= 1'b0;
      game_over_q  <= 1'b0;
      fire_cnt_q   <= 8'd0;
      hit_q        <= 1'b0;
      paddle_q     <= 1'b0;
      start_q      <= 1'b0;
      start_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      speed_q      <= speed_d;
      wave_q       <= wave_d;
      lives_q      <= lives_d;
      group_rst_q  <= group_rst_d;
      freeze_q     <= freeze_d;
      fire_q       <= fire_d;
      game_over_q  <= game_over_d;
      fire_cnt_q   <= fire_cnt_d;
      hit_q        <= hit_d;
      paddle_q     <= paddle_d;
      start_q      <= start_d;
      start_prev_q <= start_prev_d;
    end
  end

  assign bus.speed     = speed_q;
  assign bus.group_rst = group_rst_q;
  assign bus.freeze    = freeze_q;
  assign bus.fire_req  = fire_q;
  assign bus.wave_num  = wave_q;
  assign bus.lives     = lives_q;
  assign bus.game_over = game_over_q;
  assign bus.state     = state_q;
endmodule

// File: tb/tb_alien_wave_ctrl.sv
// tb/tb_alien_wave_ctrl.sv - frame-level reference model bench for alien_wave_ctrl
module tb_alien_wave_ctrl;
  import alien_wave_ctrl_pkg::*;

  localparam int TA      = 40;
  localparam int AW      = $clog2(TA + 1);
  localparam int LIVES0  = 3;
  localparam int SPAWN_N = 60;
  localparam int CLEAR_N = 90;
  localparam int RESP_N  = 120;

  logic pixel_clk = 1'b0;
  logic rst_n;
  always #5 pixel_clk = ~pixel_clk;

  alien_wave_ctrl_if #(.TOTAL_ALIENS(TA)) bus ();

  alien_wave_ctrl #(.TOTAL_ALIENS(TA)) dut (
    .pixel_clk (pixel_clk),
    .rst_n     (rst_n),
    .bus       (bus)
  );

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model state, advanced once per frame.
  wave_state_t m_state;
  int m_speed, m_wave, m_lives, m_dwell, m_since_fire, m_rem;
  bit m_fire, m_hit, m_pad, m_start;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int speed_of(input int wave, input int rem);
    int r = (rem > TA) ? TA : rem;
    int s = 1 + wave + (TA - r) / 8;
    return (s > 8) ? 8 : s;
  endfunction

  function automatic int period_of(input int wave);
    int p = 60 - wave * 6;
    return (p < 12) ? 12 : p;
  endfunction

  task automatic model_reset();
    m_state = IDLE; m_speed = 0; m_wave = 0; m_lives = LIVES0;
    m_dwell = 0; m_since_fire = 0; m_fire = 0;
    m_hit = 0; m_pad = 0; m_start = 0; m_rem = 0;
  endtask

  task automatic model_frame();
    wave_state_t nxt = m_state;
    m_fire = 0;
    case (m_state)
      IDLE, GAME_OVER: if (m_start) begin nxt = SPAWN; m_wave = 0; m_lives = LIVES0; end
      SPAWN:     begin m_dwell++; if (m_dwell == SPAWN_N) nxt = PLAY; end
      LIFE_LOST: begin m_dwell++; if (m_dwell == RESP_N) nxt = PLAY; end
      CLEARED: begin
        m_dwell++;
        if (m_dwell == CLEAR_N) begin nxt = SPAWN; m_wave = (m_wave >= 15) ? 15 : m_wave + 1; end
      end
      PLAY: begin
        if (m_pad) begin nxt = GAME_OVER; m_lives = 0; end
        else if (m_hit) begin
          if (m_lives == 1) begin nxt = GAME_OVER; m_lives = 0; end
          else begin nxt = LIFE_LOST; m_lives--; end
        end else if (m_rem == 0) nxt = CLEARED;
      end
      default: nxt = IDLE;
    endcase
    if (nxt == PLAY) begin
      m_speed = speed_of(m_wave, m_rem);
      if (m_state != PLAY) m_since_fire = 0;
      else begin
        m_since_fire++;
        if (m_since_fire == period_of(m_wave)) begin
          m_since_fire = 0;
          m_fire = (m_rem != 0);
        end
      end
    end
    if (nxt != m_state) m_dwell = 0;
    m_state = nxt;
    m_hit = 0; m_pad = 0; m_start = 0;
  endtask

  task automatic check_all();
    chk("state",     32'(bus.state),     32'(m_state));
    chk("speed",     32'(bus.speed),     32'(m_speed));
    chk("group_rst", 32'(bus.group_rst), 32'(m_state == IDLE || m_state == SPAWN));
    chk("freeze",    32'(bus.freeze),    32'(m_state != PLAY));
    chk("fire_req",  32'(bus.fire_req),  32'(m_fire));
    chk("wave_num",  32'(bus.wave_num),  32'(m_wave));
    chk("lives",     32'(bus.lives),     32'(m_lives));
    chk("game_over", 32'(bus.game_over), 32'(m_state == GAME_OVER));
  endtask

  // One 4-cycle frame: hmode 0 none, 1 hit pulse mid-frame, 2 hit on the fsync cycle.
  task automatic do_frame(input int rem, input int hmode, input bit pad, input bit start);
    @(negedge pixel_clk);
    chk("fire_single_cycle", 32'(bus.fire_req), 32'd0);
    bus.aliens_remaining     = AW'(rem);
    bus.player_hit           = (hmode == 1);
    bus.alien_reached_paddle = pad;
    bus.start_btn            = start;
    m_rem = rem;
    if (hmode != 0) m_hit = 1;
    m_pad = pad;
    if (start) m_start = 1;
    @(negedge pixel_clk);
    bus.player_hit = 1'b0;
    bus.start_btn  = 1'b0;
    @(negedge pixel_clk);
    bus.fsync      = 1'b1;
    bus.player_hit = (hmode == 2);
    model_frame();
    @(negedge pixel_clk);
    bus.fsync      = 1'b0;
    bus.player_hit = 1'b0;
    check_all();
  endtask

  task automatic rand_frame();
    do_frame(int'($urandom_range(0, 63)), int'($urandom_range(0, 2)), $urandom_range(0, 1) == 1, 1'b0);
  endtask

  task automatic spawn_to_play();
    repeat (SPAWN_N - 1) rand_frame();
    do_frame(TA, 0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.fsync = 1'b0; bus.start_btn = 1'b0; bus.aliens_remaining = AW'(TA);
    bus.alien_reached_paddle = 1'b0; bus.player_hit = 1'b0;
    model_reset();
    repeat (2) @(negedge pixel_clk);
    check_all();
    rst_n = 1'b1;
    @(negedge pixel_clk);
    check_all();

    repeat (3) rand_frame();
    do_frame(TA, 0, 1'b0, 1'b1);
    chk("start_to_spawn", 32'(bus.state), 32'(SPAWN));
    spawn_to_play();
    chk("play_entry_state", 32'(bus.state), 32'(PLAY));
    chk("play_entry_speed", 32'(bus.speed), 32'd1);
    chk("play_group_rst", 32'(bus.group_rst), 32'd0);

    for (int i = 1; i <= 120; i++) begin
      do_frame(TA, 0, 1'b0, 1'b0);
      chk("fire_wave0", 32'(bus.fire_req), 32'(i % 60 == 0));
    end
    do_frame(24, 0, 1'b0, 1'b0);
    chk("speed_ramp", 32'(bus.speed), 32'd3);
    repeat (40) do_frame(int'($urandom_range(1, 63)), 0, 1'b0, 1'b0);

    do_frame(0, 1, 1'b0, 1'b0);
    chk("hit_rem0_lifelost", 32'(bus.state), 32'(LIFE_LOST));
    chk("hit_lives2", 32'(bus.lives), 32'd2);
    repeat (RESP_N - 1) rand_frame();
    do_frame(30, 0, 1'b0, 1'b0);
    chk("respawn_play", 32'(bus.state), 32'(PLAY));
    repeat (3) do_frame(int'($urandom_range(1, 40)), 0, 1'b0, 1'b0);
    do_frame(30, 2, 1'b0, 1'b0);
    chk("hit_on_fsync_lives1", 32'(bus.lives), 32'd1);
    repeat (RESP_N - 1) rand_frame();
    do_frame(30, 0, 1'b0, 1'b0);
    repeat (2) do_frame(int'($urandom_range(1, 40)), 0, 1'b0, 1'b0);

    do_frame(0, 0, 1'b0, 1'b0);
    chk("clear_state", 32'(bus.state), 32'(CLEARED));
    repeat (CLEAR_N) rand_frame();
    chk("wave1_spawn", 32'(bus.wave_num), 32'd1);
    spawn_to_play();

    for (int it = 1; it <= 15; it++) begin
      if (it == 9) begin
        for (int i = 1; i <= 24; i++) begin
          do_frame(TA, 0, 1'b0, 1'b0);
          chk("fire_wave9", 32'(bus.fire_req), 32'(i % 12 == 0));
        end
      end else begin
        repeat (3) do_frame(int'($urandom_range(1, 63)), 0, 1'b0, 1'b0);
      end
      if (it == 15) chk("speed_sat", 32'(bus.speed), 32'd8);
      do_frame(0, 0, 1'b0, 1'b0);
      repeat (CLEAR_N) rand_frame();
      chk("wave_inc", 32'(bus.wave_num), 32'((it + 1 > 15) ? 15 : it + 1));
      spawn_to_play();
    end

    do_frame(20, 1, 1'b0, 1'b0);
    chk("last_life_gameover", 32'(bus.game_over), 32'd1);
    chk("last_life_lives", 32'(bus.lives), 32'd0);
    repeat (3) rand_frame();
    do_frame(TA, 0, 1'b0, 1'b1);
    chk("restart_wave", 32'(bus.wave_num), 32'd0);
    chk("restart_lives", 32'(bus.lives), 32'd3);
    spawn_to_play();
    repeat (2) do_frame(35, 0, 1'b0, 1'b0);
    do_frame(0, 1, 1'b1, 1'b0);
    chk("paddle_priority", 32'(bus.state), 32'(GAME_OVER));

    do_frame(TA, 0, 1'b0, 1'b1);
    spawn_to_play();
    repeat (59) do_frame(TA, 0, 1'b0, 1'b0);
    @(negedge pixel_clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge pixel_clk);
    rst_n = 1'b1;
    repeat (3) do_frame(TA, 0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
